mcu_packet_reader: RTL

SPI master that reads one 16-byte sensor packet from the FPGA's MCU-facing SPI slave (`spi_slave_mcu`) and unpacks it into quaternion and gyro fields. It is the master end of the CS-framed, read-only MCU link. It is used as an on-chip or second-board loopback reader for link bring-up, and as the reference master in hardware-in-loop benches.

Packet format, 16 bytes, MSB-first on the wire:
- byte 0: header `8'hAA`
- byte 1: flags `{6'b0, gyro_valid, quat_valid}`
- bytes 2–9: `quat_w`, `quat_x`, `quat_y`, `quat_z`, each 16-bit signed, high byte first
- bytes 10–15: `gyro_x`, `gyro_y`, `gyro_z`, each 16-bit signed, high byte first

---
 rtl/mcu_packet_reader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mcu_packet_reader.sv
// mcu_packet_reader: mode-0 SPI master that reads one 16-byte sensor packet and unpacks
// the quaternion and gyro fields, keeping the last packet whose header byte was good.
module mcu_packet_reader #(
  parameter int          CLK_DIV  = 2,
  parameter int          CS_SETUP = 2,
  parameter int          CS_HOLD  = 2,
  parameter logic [7:0]  HEADER   = 8'hAA
) (
  input  logic               clk,
  input  logic               fpga_rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               hdr_error,
  output logic               sck,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic        [15:0] pkt_count
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, DONE} state_t;
  localparam logic [15:0] DIV_L   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_L = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_L  = 16'(CS_HOLD - 1);
  state_t        state;
  logic [15:0]   cnt;
  logic [6:0]    bit_cnt;
  logic [127:0]  sr;
  assign mosi = 1'b0;
  always_ff @(posedge clk or negedge fpga_rst_n)
    if (!fpga_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hdr_error  <= 1'b0;
      sck        <= 1'b0;
      cs_n       <= 1'b1;
      quat_valid <= 1'b0;
      gyro_valid <= 1'b0;
      quat_w     <= '0;
      quat_x     <= '0;
      quat_y     <= '0;
      quat_z     <= '0;
      gyro_x     <= '0;
      gyro_y     <= '0;
      gyro_z     <= '0;
      pkt_count  <= '0;
    end else begin
      done      <= 1'b0;
      hdr_error <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state <= SETUP;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        SETUP:
          if (cnt == SETUP_L) begin
            state <= LOW;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        LOW:
          if (cnt == DIV_L) begin
            state <= HIGH;
            sck   <= 1'b1;
            cnt   <= '0;
          end else cnt <= cnt + 16'd1;
        HIGH:
          if (cnt == DIV_L) begin
            sr      <= {sr[126:0], miso};
            bit_cnt <= bit_cnt + 7'd1;
            sck     <= 1'b0;
            cnt     <= '0;
            state   <= (bit_cnt == 7'd127) ? HOLD : LOW;
          end else cnt <= cnt + 16'd1;
        HOLD:
          if (cnt == HOLD_L) begin
            state <= DONE;
            cs_n  <= 1'b1;
            done  <= 1'b1;
            cnt   <= '0;
            if (sr[127:120] == HEADER) begin
              gyro_valid <= sr[113];
              quat_valid <= sr[112];
              quat_w     <= sr[111:96];
              quat_x     <= sr[95:80];
              quat_y     <= sr[79:64];
              quat_z     <= sr[63:48];
              gyro_x     <= sr[47:32];
              gyro_y     <= sr[31:16];
              gyro_z     <= sr[15:0];
              pkt_count  <= pkt_count + 16'd1;
            end else hdr_error <= 1'b1;
          end else cnt <= cnt + 16'd1;
        DONE:
          // a held start chains straight into the next packet so cs_n is high for DONE only
          if (start) begin
            state <= SETUP;
            cs_n  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
